alu_issue_unit: RTL

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

---
 rtl/alu_issue_pkg.sv | 53 +++++
 rtl/regfile4x8.sv | 34 +++
 rtl/alu_issue_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue unit: opcodes, FSM states, LDI immediates
// and the small decode helpers used by the control path.
package alu_issue_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_CMP = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_LDI = 3'b110,
        OP_NOP = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_e;

    // Two-bit rs field sign-extended to a full register value
    localparam logic [DATA_W-1:0] LDI_IMM_00 = 8'h00;
    localparam logic [DATA_W-1:0] LDI_IMM_01 = 8'h01;
    localparam logic [DATA_W-1:0] LDI_IMM_10 = 8'hFE;
    localparam logic [DATA_W-1:0] LDI_IMM_11 = 8'hFF;

    typedef struct packed {
        op_e        op;
        logic [1:0] rd;
        logic [1:0] rs;
    } ir_t;

    function automatic logic [DATA_W-1:0] ldi_imm(input logic [1:0] field);
        case (field)
            2'b00:   return LDI_IMM_00;
            2'b01:   return LDI_IMM_01;
            2'b10:   return LDI_IMM_10;
            default: return LDI_IMM_11;
        endcase
    endfunction

    function automatic logic is_alu_op(input op_e op);
        return op inside {OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR};
    endfunction

    function automatic logic writes_reg(input op_e op);
        return (is_alu_op(op) && (op != OP_CMP)) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/regfile4x8.sv
// Four 8-bit general registers: two combinational read ports, one clocked write
// port, cleared asynchronously.
module regfile4x8
    import alu_issue_pkg::*;
#(
    parameter int NREGS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        raddr1,
    input  logic [1:0]        raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/alu_issue_unit.sv
// Single-issue sequencer: latches one instruction, presents operands to an
// external ALU for one cycle, then writes back the captured result and flags.
module alu_issue_unit
    import alu_issue_pkg::*;
#(
    parameter int NREGS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [2:0]        alu_mode,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_carry,
    output logic              wb_valid,
    output logic [1:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_zero,
    output logic              flag_carry
);

    state_e            state, state_nxt;
    ir_t               ir;
    logic [DATA_W-1:0] res_p1;
    logic              zero_p1, carry_p1;
    logic [DATA_W-1:0] rd_val, rs_val;
    logic [DATA_W-1:0] wr_data;
    logic              unused_instr_bit;

    assign unused_instr_bit = instr[4];

    regfile4x8 #(.NREGS(NREGS)) u_regfile (
        .clk    (clk),
        .rst    (reset),
        .we     (wb_valid),
        .waddr  (ir.rd),
        .wdata  (wr_data),
        .raddr1 (ir.rd),
        .raddr2 (ir.rs),
        .rdata1 (rd_val),
        .rdata2 (rs_val)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage 0: instruction register, loaded only on a handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir <= '0;
        end else if (instr_valid && instr_ready) begin
            ir <= '{op: op_e'(instr[7:5]), rd: instr[3:2], rs: instr[1:0]};
        end
    end

    always_comb begin
        alu_in1  = '0;
        alu_in2  = '0;
        alu_mode = OP_NOP;
        if ((state == ST_EXEC) && is_alu_op(ir.op)) begin
            alu_in1  = rd_val;
            alu_in2  = rs_val;
            alu_mode = ir.op;
        end
    end

    // Stage 1: ALU result and flags captured at the end of EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_p1   <= '0;
            zero_p1  <= 1'b0;
            carry_p1 <= 1'b0;
        end else if (state == ST_EXEC) begin
            res_p1   <= alu_out;
            zero_p1  <= alu_zero;
            carry_p1 <= alu_carry;
        end
    end

    // Stage 2: write-back and architectural flag update
    assign wr_data  = (ir.op == OP_LDI) ? ldi_imm(ir.rs) : res_p1;
    assign wb_valid = (state == ST_WB) && writes_reg(ir.op);
    assign wb_addr  = wb_valid ? ir.rd : 2'b00;
    assign wb_data  = wb_valid ? wr_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else if (state == ST_WB) begin
            case (ir.op)
                OP_ADD, OP_SUB, OP_CMP: begin
                    flag_zero  <= zero_p1;
                    flag_carry <= carry_p1;
                end
                OP_AND, OP_OR, OP_XOR: begin
                    flag_zero  <= zero_p1;
                    flag_carry <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
